// File: rtl/seq_div_16x8.sv
// Sequential radix-2 restoring divider: unsigned N_WIDTH-bit dividend over D_WIDTH-bit
// divisor, one quotient bit per clock, with valid/ready handshakes on both sides.
module seq_div_16x8 #(
  parameter int N_WIDTH = 16,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_WIDTH-1:0] dividend,
  input  logic [D_WIDTH-1:0] divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N_WIDTH-1:0] quotient,
  output logic [D_WIDTH-1:0] remainder,
  output logic               div_by_zero
);

  localparam int CNT_W = $clog2(N_WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state;
  logic [N_WIDTH-1:0] shift_q;
  logic [D_WIDTH-1:0] dvsr;
  logic [D_WIDTH-1:0] part_rem;
  logic [CNT_W-1:0]   count;

  logic [D_WIDTH:0]   rem_shift;
  logic               q_bit;
  logic [D_WIDTH-1:0] rem_diff;

  // The partial remainder always stays below the divisor, so once the trial subtraction
  // succeeds the difference fits back into D_WIDTH bits.
  assign rem_shift = {part_rem, shift_q[N_WIDTH-1]};
  assign q_bit     = (rem_shift >= {1'b0, dvsr});
  assign rem_diff  = rem_shift[D_WIDTH-1:0] - dvsr;

  // The dividend register doubles as the quotient register: each cycle it shifts left,
  // and the new quotient bit enters at the LSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      shift_q     <= '0;
      dvsr        <= '0;
      part_rem    <= '0;
      count       <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            shift_q  <= dividend;
            dvsr     <= divisor;
            part_rem <= '0;
            count    <= CNT_W'(N_WIDTH - 1);
            if (divisor == '0) begin
              state       <= DONE;
              out_valid   <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend[D_WIDTH-1:0];
              div_by_zero <= 1'b1;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          shift_q  <= {shift_q[N_WIDTH-2:0], q_bit};
          part_rem <= q_bit ? rem_diff : rem_shift[D_WIDTH-1:0];
          if (count == '0) begin
            state <= DONE;
          end else begin
            count <= count - 1'b1;
          end
        end
        DONE: begin
          // First DONE cycle publishes the result; afterwards it is held until taken.
          if (!out_valid) begin
            out_valid   <= 1'b1;
            quotient    <= shift_q;
            remainder   <= part_rem;
            div_by_zero <= 1'b0;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
